// File: rtl/eth_point_extractor.sv
// rtl/eth_point_extractor.sv - EtherType-filtered point-record extractor feeding display_controller
//
// Parses Ethernet frames from the receive MAC, keeps the payload of one good
// frame as 8-byte records and replays them one per RECORD_PERIOD cycles on
// an 8-byte window with a one-cycle doorbell per record.
//
// Ports:
//   clock_in              system clock
//   reset_in              asynchronous active-high reset
//   rx_data/valid/last    received byte stream, no backpressure, FCS stripped
//   rx_err                frame error, sampled with rx_last
//   pkt_buf_out[0..7]     current record, [0] = record type byte
//   pkt_buf_doorbell_out  one-cycle pulse, record on pkt_buf_out is valid
//   busy                  high while replaying records
//   frames_accepted       good frames replayed (wrapping)
//   frames_dropped        rejected or overlapped frames (wrapping)

module eth_point_extractor #(
   parameter logic [15:0] ETHERTYPE     = 16'h88B5,
   parameter int          MAX_RECORDS   = 187,
   parameter int          RECORD_PERIOD = 16
) (
   input  logic            clock_in,
   input  logic            reset_in,
   input  logic [7:0]      rx_data,
   input  logic            rx_valid,
   input  logic            rx_last,
   input  logic            rx_err,
   output logic [7:0][7:0] pkt_buf_out,
   output logic            pkt_buf_doorbell_out,
   output logic            busy,
   output logic [15:0]     frames_accepted,
   output logic [15:0]     frames_dropped
);

   localparam int            AW      = $clog2(MAX_RECORDS + 1);
   localparam logic [AW-1:0] MAX_IDX = AW'(MAX_RECORDS);
   localparam logic [AW-1:0] ONE_IDX = AW'(1);
   localparam logic [15:0]   PH_LAST = 16'(RECORD_PERIOD - 1);
   // Drain ends on phase 3 of the final record: load at 0, doorbell out at 2, busy tail at 3.
   localparam logic [15:0]   PH_DONE = 16'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_PAYLOAD,
      S_DISCARD,
      S_DRAIN
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      hdr_cnt_q, hdr_cnt_d;
   logic [2:0]      lane_q, lane_d;
   logic [AW-1:0]   idx_q, idx_d;       // write index in PAYLOAD, read index in DRAIN
   logic [AW-1:0]   rec_n_q, rec_n_d;
   logic [15:0]     phase_q, phase_d;
   logic            mid_frame_q, mid_frame_d;
   logic [6:0][7:0] asm_q, asm_d;       // lanes 0..6; lane 7 goes straight to the store
   logic [7:0][7:0] pkt_buf_q, pkt_buf_d;
   logic            db_q, db_d;
   logic [15:0]     acc_q, acc_d;
   logic [15:0]     drop_q, drop_d;

   logic [63:0]     store [MAX_RECORDS];
   logic            store_we;
   logic [63:0]     store_wdata;

   always_comb begin
      state_d     = state_q;
      hdr_cnt_d   = hdr_cnt_q;
      lane_d      = lane_q;
      idx_d       = idx_q;
      rec_n_d     = rec_n_q;
      phase_d     = phase_q;
      mid_frame_d = mid_frame_q;
      asm_d       = asm_q;
      pkt_buf_d   = pkt_buf_q;
      db_d        = 1'b0;
      acc_d       = acc_q;
      drop_d      = drop_q;
      store_we    = 1'b0;
      store_wdata = {rx_data, asm_q};

      case (state_q)
         S_IDLE: begin
            if (rx_valid) begin
               if (rx_last) begin
                  drop_d = drop_q + 16'd1;
               end else begin
                  state_d   = S_HEADER;
                  hdr_cnt_d = 4'd1;
               end
            end
         end

         S_HEADER: begin
            if (rx_valid) begin
               hdr_cnt_d = hdr_cnt_q + 4'd1;
               if (rx_last && hdr_cnt_q == 4'd13 && rx_data == ETHERTYPE[7:0]) begin
                  // Header-only frame with the right type: nothing to replay, nothing to count.
                  state_d = S_IDLE;
               end else if (rx_last) begin
                  drop_d  = drop_q + 16'd1;
                  state_d = S_IDLE;
               end else if (hdr_cnt_q == 4'd12 && rx_data != ETHERTYPE[15:8]) begin
                  state_d = S_DISCARD;
               end else if (hdr_cnt_q == 4'd13) begin
                  if (rx_data == ETHERTYPE[7:0]) begin
                     state_d = S_PAYLOAD;
                     idx_d   = '0;
                     lane_d  = 3'd0;
                  end else begin
                     state_d = S_DISCARD;
                  end
               end
            end
         end

         S_PAYLOAD: begin
            if (rx_valid) begin
               if (idx_q == MAX_IDX) begin
                  // Store already full: this byte makes the frame oversize.
                  if (rx_last) begin
                     drop_d  = drop_q + 16'd1;
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_DISCARD;
                  end
               end else begin
                  lane_d = lane_q + 3'd1;
                  if (lane_q == 3'd7) begin
                     store_we = 1'b1;
                     idx_d    = idx_q + ONE_IDX;
                  end else begin
                     asm_d[lane_q] = rx_data;
                  end
                  if (rx_last) begin
                     if (rx_err) begin
                        drop_d  = drop_q + 16'd1;
                        state_d = S_IDLE;
                     end else if (idx_d == '0) begin
                        state_d = S_IDLE;
                     end else begin
                        acc_d       = acc_q + 16'd1;
                        state_d     = S_DRAIN;
                        rec_n_d     = idx_d;
                        idx_d       = '0;
                        phase_d     = 16'd0;
                        mid_frame_d = 1'b0;
                     end
                  end
               end
            end
         end

         S_DISCARD: begin
            if (rx_valid && rx_last) begin
               drop_d  = drop_q + 16'd1;
               state_d = S_IDLE;
            end
         end

         S_DRAIN: begin
            // The store read lands directly in the output register one cycle later.
            if (phase_q == 16'd0) begin
               pkt_buf_d = store[idx_q];
            end
            if (phase_q == 16'd1) begin
               db_d = 1'b1;
            end
            if (phase_q == PH_LAST) begin
               phase_d = 16'd0;
               idx_d   = idx_q + ONE_IDX;
            end else begin
               phase_d = phase_q + 16'd1;
            end
            // Traffic arriving now cannot be stored; only track frame boundaries.
            if (rx_valid) begin
               mid_frame_d = !rx_last;
               if (rx_last) begin
                  drop_d = drop_q + 16'd1;
               end
            end
            if (idx_q == rec_n_q - ONE_IDX && phase_q == PH_DONE) begin
               state_d     = mid_frame_d ? S_DISCARD : S_IDLE;
               mid_frame_d = 1'b0;
               idx_d       = '0;
               phase_d     = 16'd0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state_q     <= S_IDLE;
         hdr_cnt_q   <= 4'd0;
         lane_q      <= 3'd0;
         idx_q       <= '0;
         rec_n_q     <= '0;
         phase_q     <= 16'd0;
         mid_frame_q <= 1'b0;
         asm_q       <= '0;
         pkt_buf_q   <= '0;
         db_q        <= 1'b0;
         acc_q       <= 16'd0;
         drop_q      <= 16'd0;
      end else begin
         state_q     <= state_d;
         hdr_cnt_q   <= hdr_cnt_d;
         lane_q      <= lane_d;
         idx_q       <= idx_d;
         rec_n_q     <= rec_n_d;
         phase_q     <= phase_d;
         mid_frame_q <= mid_frame_d;
         asm_q       <= asm_d;
         pkt_buf_q   <= pkt_buf_d;
         db_q        <= db_d;
         acc_q       <= acc_d;
         drop_q      <= drop_d;
      end
   end

   always_ff @(posedge clock_in) begin
      if (store_we) begin
         store[idx_q] <= store_wdata;
      end
   end

   assign pkt_buf_out          = pkt_buf_q;
   assign pkt_buf_doorbell_out = db_q;
   assign busy                 = (state_q == S_DRAIN);
   assign frames_accepted      = acc_q;
   assign frames_dropped       = drop_q;

endmodule

// File: tb/tb_eth_point_extractor.sv
// tb/tb_eth_point_extractor.sv - self-checking bench for eth_point_extractor

module tb_eth_point_extractor;

   localparam int RP   = 16;
   localparam int MAXR = 187;

   logic            clock_in = 1'b0;
   logic            reset_in = 1'b1;
   logic [7:0]      rx_data  = 8'h00;
   logic            rx_valid = 1'b0;
   logic            rx_last  = 1'b0;
   logic            rx_err   = 1'b0;
   logic [7:0][7:0] pkt_buf_out;
   logic            pkt_buf_doorbell_out;
   logic            busy;
   logic [15:0]     frames_accepted;
   logic [15:0]     frames_dropped;

   eth_point_extractor #(
      .ETHERTYPE    (16'h88B5),
      .MAX_RECORDS  (MAXR),
      .RECORD_PERIOD(RP)
   ) dut (
      .clock_in            (clock_in),
      .reset_in            (reset_in),
      .rx_data             (rx_data),
      .rx_valid            (rx_valid),
      .rx_last             (rx_last),
      .rx_err              (rx_err),
      .pkt_buf_out         (pkt_buf_out),
      .pkt_buf_doorbell_out(pkt_buf_doorbell_out),
      .busy                (busy),
      .frames_accepted     (frames_accepted),
      .frames_dropped      (frames_dropped)
   );

   always #5 clock_in = ~clock_in;

   int n_compared   = 0;
   int n_mismatched = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         if (n_mismatched <= 40)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          cyc = 0;
   logic [15:0] m_acc = 16'd0;
   logic [15:0] m_drop = 16'd0;
   bit          have_drain = 1'b0;
   int          d_t0 = 0;
   int          d_n = 0;
   logic [63:0] d_recs[$];
   logic [63:0] hold = 64'd0;
   logic [7:0]  fq[$];
   bit          discarding = 1'b0;
   bit          mid = 1'b0;

   function automatic int d_end();
      return d_t0 + 4 + (d_n - 1) * RP;
   endfunction

   function automatic bit exp_busy(input int c);
      return have_drain && c >= d_t0 + 1 && c <= d_end();
   endfunction

   function automatic bit exp_db(input int c);
      if (!have_drain || c < d_t0 + 3) return 1'b0;
      return ((c - d_t0 - 3) % RP == 0) && ((c - d_t0 - 3) / RP < d_n);
   endfunction

   function automatic logic [63:0] exp_pkt(input int c);
      int k;
      if (!have_drain || c < d_t0 + 2) return hold;
      k = (c - d_t0 - 2) / RP;
      if (k > d_n - 1) k = d_n - 1;
      return d_recs[k];
   endfunction

   task automatic model_reset();
      m_acc = 16'd0;
      m_drop = 16'd0;
      have_drain = 1'b0;
      hold = 64'd0;
      d_recs.delete();
      fq.delete();
      discarding = 1'b0;
      mid = 1'b0;
   endtask

   task automatic classify(input logic e, input int c);
      int L;
      int plen;
      logic [63:0] rec;
      L = fq.size();
      plen = L - 14;
      if (L <= 13) m_drop++;
      else if (fq[12] != 8'h88 || fq[13] != 8'hB5) m_drop++;
      else if (plen > 8 * MAXR) m_drop++;
      else if (e) m_drop++;
      else if (plen / 8 > 0) begin
         if (have_drain) hold = d_recs[d_n - 1];
         d_recs.delete();
         for (int k = 0; k < plen / 8; k++) begin
            rec = 64'd0;
            for (int j = 0; j < 8; j++) rec[8*j +: 8] = fq[14 + 8*k + j];
            d_recs.push_back(rec);
         end
         d_n = plen / 8;
         d_t0 = c;
         have_drain = 1'b1;
         m_acc++;
      end
   endtask

   task automatic model_byte(input int c, input logic [7:0] d, input logic l, input logic e);
      if (exp_busy(c)) begin
         if (l) begin
            m_drop++;
            mid = 1'b0;
         end else begin
            mid = 1'b1;
         end
         if (c == d_end()) begin
            if (mid) discarding = 1'b1;
            mid = 1'b0;
         end
      end else if (discarding) begin
         if (l) begin
            m_drop++;
            discarding = 1'b0;
         end
      end else begin
         fq.push_back(d);
         if (l) begin
            classify(e, c);
            fq.delete();
         end
      end
   endtask

   always @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         model_reset();
      end else begin
         if (rx_valid) model_byte(cyc, rx_data, rx_last, rx_err);
         cyc = cyc + 1;
      end
   end

   // ---------------- per-cycle compare ----------------
   int          db_cyc[$];
   logic [63:0] db_data[$];
   logic [63:0] cmp_pb;

   always @(negedge clock_in) begin
      cmp_pb = pkt_buf_out;
      check("pkt_buf", cmp_pb, exp_pkt(cyc));
      check("doorbell", 64'(pkt_buf_doorbell_out), 64'(exp_db(cyc)));
      check("busy", 64'(busy), 64'(exp_busy(cyc)));
      check("frames_accepted", 64'(frames_accepted), 64'(m_acc));
      check("frames_dropped", 64'(frames_dropped), 64'(m_drop));
      if (pkt_buf_doorbell_out) begin
         db_cyc.push_back(cyc);
         db_data.push_back(cmp_pb);
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] tx_q[$];
   int         last_t0;

   task automatic step();
      @(posedge clock_in);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic e);
      rx_valid = v;
      rx_data  = d;
      rx_last  = l;
      rx_err   = e;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'b0, 1'b0);
   endtask

   task automatic build(input logic [15:0] etype, input int plen, input int kind);
      tx_q.delete();
      for (int i = 0; i < 12; i++) tx_q.push_back(8'($urandom));
      tx_q.push_back(etype[15:8]);
      tx_q.push_back(etype[7:0]);
      for (int i = 0; i < plen; i++) begin
         if (kind == 0) tx_q.push_back(8'(i + 1));
         else if (kind == 1) tx_q.push_back(8'(i));
         else tx_q.push_back(8'($urandom));
      end
   endtask

   task automatic send_frame(input logic err, input int gap_pct);
      for (int i = 0; i < tx_q.size(); i++) begin
         if (i > 0 && int'($urandom_range(0, 99)) < gap_pct) idle(int'($urandom_range(1, 3)));
         if (i == tx_q.size() - 1) begin
            last_t0 = cyc;
            drive(1'b1, tx_q[i], 1'b1, err);
         end else begin
            drive(1'b1, tx_q[i], 1'b0, 1'($urandom));
         end
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic wait_quiet(input int budget);
      int n;
      n = 0;
      idle(2);
      while (busy && n < budget) begin
         idle(1);
         n++;
      end
      check("drain_timeout", 64'(busy), 64'd0);
      idle(3);
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      rx_last  = 1'b0;
      rx_err   = 1'b0;
      reset_in = 1'b1;
      step();
      step();
      reset_in = 1'b0;
      step();
      db_cyc.delete();
      db_data.delete();
   endtask

   logic [63:0] t1_rec [3];
   int          t0;
   int          r;

   initial begin
      t1_rec[0] = 64'h0807060504030201;
      t1_rec[1] = 64'h100F0E0D0C0B0A09;
      t1_rec[2] = 64'h1817161514131211;

      step();
      step();
      check("reset_pkt_buf", pkt_buf_out, 64'd0);
      check("reset_doorbell", 64'(pkt_buf_doorbell_out), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_accepted", 64'(frames_accepted), 64'd0);
      check("reset_dropped", 64'(frames_dropped), 64'd0);
      reset_in = 1'b0;
      step();

      // good frame, 24 payload bytes 01..18
      do_reset();
      build(16'h88B5, 24, 0);
      send_frame(1'b0, 0);
      t0 = last_t0;
      wait_quiet(400);
      check("t1_db_count", 64'(db_cyc.size()), 64'd3);
      for (int i = 0; i < 3 && i < db_cyc.size(); i++) begin
         check("t1_db_time", 64'(db_cyc[i] - t0), 64'(3 + 16 * i));
         check("t1_record", db_data[i], t1_rec[i]);
      end
      check("t1_accepted", 64'(frames_accepted), 64'd1);

      // wrong EtherType, then one-record frame
      do_reset();
      build(16'h0800, 16, 2);
      send_frame(1'b0, 0);
      idle(10);
      check("t2_db_count_a", 64'(db_cyc.size()), 64'd0);
      check("t2_dropped", 64'(frames_dropped), 64'd1);
      build(16'h88B5, 8, 2);
      tx_q[14] = 8'hAA;
      for (int j = 1; j < 8; j++) tx_q[14 + j] = 8'(8'hA0 + j);
      send_frame(1'b0, 0);
      wait_quiet(200);
      check("t2_db_count_b", 64'(db_cyc.size()), 64'd1);
      if (db_data.size() > 0) check("t2_record", db_data[0], 64'hA7A6A5A4A3A2A1AA);

      // 19 payload bytes: trailing partial record dropped
      do_reset();
      build(16'h88B5, 19, 0);
      send_frame(1'b0, 20);
      wait_quiet(400);
      check("t3_db_count", 64'(db_cyc.size()), 64'd2);
      if (db_data.size() > 1) check("t3_record1", db_data[1], t1_rec[1]);

      // rx_err on final byte
      do_reset();
      build(16'h88B5, 16, 0);
      send_frame(1'b1, 0);
      idle(40);
      check("t4_db_count", 64'(db_cyc.size()), 64'd0);
      check("t4_dropped", 64'(frames_dropped), 64'd1);
      check("t4_accepted", 64'(frames_accepted), 64'd0);

      // oversize, then exactly full store
      do_reset();
      build(16'h88B5, 1500, 1);
      send_frame(1'b0, 0);
      idle(40);
      check("t5_db_count_a", 64'(db_cyc.size()), 64'd0);
      check("t5_dropped", 64'(frames_dropped), 64'd1);
      build(16'h88B5, 1496, 1);
      send_frame(1'b0, 0);
      wait_quiet(4000);
      check("t5_db_count_b", 64'(db_cyc.size()), 64'd187);
      if (db_data.size() > 186) check("t5_record186", db_data[186], 64'hD7D6D5D4D3D2D1D0);
      check("t5_accepted", 64'(frames_accepted), 64'd1);

      // frame overlapping a 10-record drain, then a normal frame
      do_reset();
      build(16'h88B5, 80, 2);
      send_frame(1'b0, 0);
      idle(18);
      build(16'h88B5, 24, 2);
      send_frame(1'b0, 0);
      wait_quiet(400);
      check("t6_dropped", 64'(frames_dropped), 64'd1);
      check("t6_accepted_a", 64'(frames_accepted), 64'd1);
      check("t6_db_count_a", 64'(db_cyc.size()), 64'd10);
      build(16'h88B5, 16, 0);
      send_frame(1'b0, 0);
      wait_quiet(400);
      check("t6_db_count_b", 64'(db_cyc.size()), 64'd12);
      check("t6_accepted_b", 64'(frames_accepted), 64'd2);

      // frame still in progress when the drain ends
      do_reset();
      build(16'h88B5, 16, 2);
      send_frame(1'b0, 0);
      idle(8);
      build(16'h88B5, 40, 2);
      send_frame(1'b0, 0);
      wait_quiet(400);
      check("t6b_dropped", 64'(frames_dropped), 64'd1);
      check("t6b_db_count", 64'(db_cyc.size()), 64'd2);

      // reset pulsed mid-drain
      do_reset();
      build(16'h88B5, 80, 2);
      send_frame(1'b0, 0);
      idle(30);
      reset_in = 1'b1;
      #1;
      check("t7_pkt_buf", pkt_buf_out, 64'd0);
      check("t7_busy", 64'(busy), 64'd0);
      check("t7_doorbell", 64'(pkt_buf_doorbell_out), 64'd0);
      check("t7_accepted", 64'(frames_accepted), 64'd0);
      step();
      step();
      reset_in = 1'b0;
      db_cyc.delete();
      db_data.delete();
      idle(200);
      check("t7_db_after", 64'(db_cyc.size()), 64'd0);

      // randomized traffic
      do_reset();
      for (int it = 0; it < 70; it++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 3) begin
            build(16'h88B5, int'($urandom_range(0, 60)), 2);
            send_frame(1'b0, 15);
         end else if (r == 4) begin
            build(16'h88B5, int'($urandom_range(0, 200)), 2);
            send_frame(1'b0, 10);
         end else if (r == 5) begin
            build(($urandom_range(0, 1) == 0) ? 16'h0800 : 16'h88B4, int'($urandom_range(0, 40)), 2);
            send_frame(1'b0, 15);
         end else if (r == 6) begin
            tx_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 14)); i++) tx_q.push_back(8'($urandom));
            if (tx_q.size() > 12) tx_q[12] = 8'h88;
            send_frame(1'b0, 10);
         end else if (r == 7) begin
            build(16'h88B5, int'($urandom_range(8, 40)), 2);
            send_frame(1'b1, 15);
         end else begin
            build(16'h88B5, 0, 2);
            send_frame(1'b0, 0);
         end
         idle(int'($urandom_range(0, 30)));
      end
      wait_quiet(5000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, compared %0d", n_compared);
      $fatal(1, "watchdog");
   end

endmodule
